// File: rtl/uart_xcvr.sv
// uart_xcvr: UART transmitter and receiver with a first-word fall-through RX FIFO.
// Optional even parity is enabled by defining the macro UART_PARITY_EN; without it
// frames are start + DATA_BITS + stop and perr is tied low.
module uart_xcvr #(
  parameter int BAUD_DIV  = 32,
  parameter int DATA_BITS = 8,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [FIFO_LOG2:0]   rx_count,
  output logic                 ferr,
  output logic                 ovf,
  output logic                 perr,
  input  logic                 clr
);

  localparam logic [15:0]        BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0]        HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0]        CNT_ONE   = 16'd1;
  localparam logic [3:0]         DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]         BIT_ONE   = 4'd1;
  localparam logic [FIFO_LOG2:0] PTR_ONE   = {{FIFO_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_BREAK} rx_state_t;

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  tx_state_t              tx_state, tx_next;
  logic                   run;
  logic [15:0]            tx_cnt;
  logic [3:0]             tx_bit;
  logic [DATA_BITS-1:0]   tx_shift;
  logic                   tx_tick;
  logic                   tx_accept;
`ifdef UART_PARITY_EN
  logic                   tx_par;
`endif

  assign tx_tick   = (tx_cnt == BIT_LAST);
  assign tx_accept = tx_valid && tx_ready;

  // Holds tx_ready low until the first edge after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run <= 1'b0;
    else     run <= 1'b1;
  end

  // Transmitter state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_next;
  end

  // Transmitter next-state: each non-idle state lasts one bit time
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:   if (tx_accept) tx_next = T_START;
      T_START:  if (tx_tick) tx_next = T_DATA;
      T_DATA:   if (tx_tick && tx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
        tx_next = T_PARITY;
`else
        tx_next = T_STOP;
`endif
      end
      T_PARITY: if (tx_tick) tx_next = T_STOP;
      T_STOP:   if (tx_tick) tx_next = T_IDLE;
      default:  tx_next = T_IDLE;
    endcase
  end

  // Transmitter outputs decoded from state; line idles high
  always_comb begin
    txd      = 1'b1;
    tx_ready = 1'b0;
    case (tx_state)
      T_IDLE:   tx_ready = run;
      T_START:  txd = 1'b0;
      T_DATA:   txd = tx_shift[0];
`ifdef UART_PARITY_EN
      T_PARITY: txd = tx_par;
`else
      T_PARITY: txd = 1'b1;
`endif
      T_STOP:   txd = 1'b1;
      default:  txd = 1'b1;
    endcase
  end

  // Bit-time counter, data shifter and parity capture for the transmitter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_cnt <= (tx_state == T_IDLE || tx_tick) ? '0 : tx_cnt + CNT_ONE;
      if (tx_accept) begin
        tx_shift <= tx_data;
        tx_bit   <= '0;
`ifdef UART_PARITY_EN
        tx_par   <= ^tx_data;
`endif
      end else if (tx_state == T_DATA && tx_tick) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + BIT_ONE;
      end
    end
  end

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  rx_state_t              rx_state, rx_next;
  logic [1:0]             rx_sync;
  logic                   rxd_s;
  logic                   rxd_prev;
  logic                   rx_fall;
  logic [15:0]            rx_cnt;
  logic [3:0]             rx_bit;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_tick;
  logic                   push;
  logic                   frame_err;
`ifdef UART_PARITY_EN
  logic                   par_err;
`endif

  assign rxd_s   = rx_sync[1];
  assign rx_fall = rxd_prev && !rxd_s;
  assign rx_tick = (rx_state == R_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rxd_prev <= rxd_s;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= R_IDLE;
    else     rx_state <= rx_next;
  end

  // Receiver next-state: mid-bit sampling, glitch rejection and break wait
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:   if (rx_fall) rx_next = R_START;
      R_START:  if (rx_tick) rx_next = rxd_s ? R_IDLE : R_DATA;
      R_DATA:   if (rx_tick && rx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
        rx_next = R_PARITY;
`else
        rx_next = R_STOP;
`endif
      end
      R_PARITY: if (rx_tick) rx_next = R_STOP;
      R_STOP:   if (rx_tick) rx_next = rxd_s ? R_IDLE : R_BREAK;
      R_BREAK:  if (rxd_s) rx_next = R_IDLE;
      default:  rx_next = R_IDLE;
    endcase
  end

  // Receiver event outputs raised on the sampling edge of stop/parity bits
  always_comb begin
    push      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_PARITY_EN
    par_err   = 1'b0;
`endif
    case (rx_state)
`ifdef UART_PARITY_EN
      R_PARITY: par_err = rx_tick && (rxd_s != ^rx_shift);
`endif
      R_STOP: begin
        push      = rx_tick && rxd_s;
        frame_err = rx_tick && !rxd_s;
      end
      default: ;
    endcase
  end

  // Bit-time counter and LSB-first data shifter for the receiver
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_cnt <= (rx_state == R_IDLE || rx_state == R_BREAK || rx_tick) ? '0 : rx_cnt + CNT_ONE;
      if (rx_state == R_START && rx_tick) begin
        rx_bit <= '0;
      end else if (rx_state == R_DATA && rx_tick) begin
        rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + BIT_ONE;
      end
    end
  end

  // Framing error reported as a registered single-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ferr <= 1'b0;
    else     ferr <= frame_err;
  end

  // ------------------------------------------------------------------
  // RX FIFO (first-word fall-through, extra pointer MSB for full/empty)
  // ------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [0:2**FIFO_LOG2-1];
  logic [FIFO_LOG2:0]   wr_ptr, rd_ptr;
  logic                 full;
  logic                 pop;
  logic                 wr_en;
  logic                 overflow;

  assign full     = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                    (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign rx_valid = (wr_ptr != rd_ptr);
  assign rx_count = wr_ptr - rd_ptr;
  assign rx_data  = mem[rd_ptr[FIFO_LOG2-1:0]];
  assign pop      = rx_valid && rx_ready;
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;

  // FIFO pointers; a write into a full FIFO is allowed only alongside a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage, written with the completed receive word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_LOG2-1:0]] <= rx_shift;
  end

  // Sticky overflow flag; a new overflow wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (overflow) ovf <= 1'b1;
    else if (clr)      ovf <= 1'b0;
  end

`ifdef UART_PARITY_EN
  // Sticky parity error flag; a new mismatch wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          perr <= 1'b0;
    else if (par_err) perr <= 1'b1;
    else if (clr)     perr <= 1'b0;
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: self-checking bench for uart_xcvr (default parameters).
// Honours UART_PARITY_EN the same way the design does.
module tb_uart_xcvr;

  localparam int BAUD = 32;
  localparam int DW   = 8;
  localparam int FL   = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd;
  logic          rxd_drv = 1'b1;
  logic          loopback = 1'b0;
  logic          txd;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [FL:0]   rx_count;
  logic          ferr;
  logic          ovf;
  logic          perr;
  logic          clr = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int ferr_cnt    = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [11:0]   frame;
  } vec_t;

  vec_t          table_v[6];
  logic [DW-1:0] q[$];
  logic [DW-1:0] ovf_words[17];

  assign rxd = loopback ? txd : rxd_drv;

  uart_xcvr #(.BAUD_DIV(BAUD), .DATA_BITS(DW), .FIFO_LOG2(FL)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count), .ferr(ferr), .ovf(ovf), .perr(perr), .clr(clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ferr) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1
  function automatic logic [11:0] mkFrame(input logic [DW-1:0] d);
    logic [11:0] f;
    f = '0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
    f[DW+1] = ^d;
`endif
    f[NBITS-1] = 1'b1;
    return f;
  endfunction

  // Send one word through the transmitter and check every cycle of txd
  task automatic sendWord(input logic [DW-1:0] d, input logic [11:0] frame, input string tag);
    int waited = 0;
    while (!tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " tx_ready before send"}, 16'(tx_ready), 16'd1);
    if (!tx_ready) return;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NBITS * BAUD; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      checkOutput({tag, " txd"}, 16'(txd), 16'(frame[k / BAUD]));
      if (k % BAUD == 0) checkOutput({tag, " tx_ready busy"}, 16'(tx_ready), 16'd0);
    end
    @(negedge clk);
    checkOutput({tag, " tx_ready return"}, 16'(tx_ready), 16'd1);
    checkOutput({tag, " txd idle"}, 16'(txd), 16'd1);
  endtask

  // Drive a frame onto rxd directly, one bit time per bit
  task automatic driveFrame(input logic [11:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd_drv = frame[i];
      repeat (BAUD) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Check the FIFO head and pop it
  task automatic popOne(input string tag, input logic [DW-1:0] expected);
    checkOutput({tag, " rx_valid"}, 16'(rx_valid), 16'd1);
    checkOutput({tag, " rx_data"}, 16'(rx_data), 16'(expected));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // One table vector: transmit in loopback, then expect the word in the FIFO
  task automatic applyStimulus(input vec_t v);
    loopback = 1'b1;
    sendWord(v.data, v.frame, "table");
    repeat (2) @(negedge clk);
    loopback = 1'b0;
    checkOutput("table rx_count", 16'(rx_count), 16'd1);
    popOne("table", v.data);
    checkOutput("table rx_count after pop", 16'(rx_count), 16'd0);
  endtask

  initial begin
    int base;
    int npop;
    logic [DW-1:0] d;

`ifdef UART_PARITY_EN
    table_v[0] = '{data: 8'h41, frame: 12'h482};
    table_v[1] = '{data: 8'h00, frame: 12'h400};
    table_v[2] = '{data: 8'hFF, frame: 12'h5FE};
    table_v[3] = '{data: 8'hA5, frame: 12'h54A};
    table_v[4] = '{data: 8'h5A, frame: 12'h4B4};
    table_v[5] = '{data: 8'h01, frame: 12'h602};
`else
    table_v[0] = '{data: 8'h41, frame: 12'h282};
    table_v[1] = '{data: 8'h00, frame: 12'h200};
    table_v[2] = '{data: 8'hFF, frame: 12'h3FE};
    table_v[3] = '{data: 8'hA5, frame: 12'h34A};
    table_v[4] = '{data: 8'h5A, frame: 12'h2B4};
    table_v[5] = '{data: 8'h01, frame: 12'h202};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset txd", 16'(txd), 16'd1);
    checkOutput("reset tx_ready", 16'(tx_ready), 16'd0);
    checkOutput("reset rx_valid", 16'(rx_valid), 16'd0);
    checkOutput("reset rx_count", 16'(rx_count), 16'd0);
    checkOutput("reset ferr", 16'(ferr), 16'd0);
    checkOutput("reset ovf", 16'(ovf), 16'd0);
    checkOutput("reset perr", 16'(perr), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tx_ready after reset", 16'(tx_ready), 16'd1);

    // Table-driven TX/RX vectors
    for (int i = 0; i < 6; i++) applyStimulus(table_v[i]);

    // Direct RX of 0xA5
    driveFrame(mkFrame(8'hA5), NBITS);
    checkOutput("rxA5 rx_count", 16'(rx_count), 16'd1);
    popOne("rxA5", 8'hA5);
    checkOutput("rxA5 rx_valid after pop", 16'(rx_valid), 16'd0);

    // Glitch of 8 cycles must be ignored
    base = ferr_cnt;
    rxd_drv = 1'b0;
    repeat (8) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (12 * BAUD) @(negedge clk);
    checkOutput("glitch rx_count", 16'(rx_count), 16'd0);
    checkOutput("glitch ferr pulses", 16'(ferr_cnt - base), 16'd0);
    driveFrame(mkFrame(8'h3C), NBITS);
    popOne("after glitch", 8'h3C);

    // Framing error: 0x00 with the line held low 12 bit times past the data
    base = ferr_cnt;
    rxd_drv = 1'b0;
    repeat ((NBITS - 1 + 12) * BAUD) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    checkOutput("break ferr pulses", 16'(ferr_cnt - base), 16'd1);
    checkOutput("break rx_count", 16'(rx_count), 16'd0);
    driveFrame(mkFrame(8'hC3), NBITS);
    popOne("after break", 8'hC3);

    // Overflow: 17 frames with no pops
    for (int i = 0; i < 17; i++) begin
      ovf_words[i] = DW'($urandom);
      driveFrame(mkFrame(ovf_words[i]), NBITS);
      if (i == 15) begin
        checkOutput("full rx_count", 16'(rx_count), 16'd16);
        checkOutput("full ovf", 16'(ovf), 16'd0);
      end
    end
    checkOutput("ovf rx_count", 16'(rx_count), 16'd16);
    checkOutput("ovf flag", 16'(ovf), 16'd1);
    for (int i = 0; i < 16; i++) begin
      popOne("ovf readback", ovf_words[i]);
      checkOutput("ovf readback rx_count", 16'(rx_count), 16'(15 - i));
    end
    checkOutput("ovf sticky", 16'(ovf), 16'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("ovf cleared", 16'(ovf), 16'd0);

    // Randomised loopback traffic against a queue model
    for (int n = 0; n < 24; n++) begin
      d = DW'($urandom);
      loopback = 1'b1;
      sendWord(d, mkFrame(d), "rand");
      @(negedge clk);
      loopback = 1'b0;
      q.push_back(d);
      checkOutput("rand rx_count", 16'(rx_count), 16'(q.size()));
      npop = (q.size() >= 12) ? q.size() : int'($urandom_range(0, q.size()));
      for (int p = 0; p < npop; p++) begin
        popOne("rand", q[0]);
        void'(q.pop_front());
        checkOutput("rand rx_count after pop", 16'(rx_count), 16'(q.size()));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    while (q.size() > 0) begin
      popOne("rand drain", q[0]);
      void'(q.pop_front());
    end
    checkOutput("rand drained", 16'(rx_valid), 16'd0);
    checkOutput("rand ovf", 16'(ovf), 16'd0);

    // Reset in the middle of a transmission
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midtx reset txd", 16'(txd), 16'd1);
    checkOutput("midtx reset tx_ready", 16'(tx_ready), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midtx tx_ready after release", 16'(tx_ready), 16'd1);
    checkOutput("midtx txd after release", 16'(txd), 16'd1);
    sendWord(8'h96, mkFrame(8'h96), "after reset");

    // Reset in the middle of a reception: no partial word
    rxd_drv = 1'b0;
    repeat (4 * BAUD) @(negedge clk);
    rst = 1'b1;
    rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BAUD) @(negedge clk);
    checkOutput("midrx rx_count", 16'(rx_count), 16'd0);
    checkOutput("midrx rx_valid", 16'(rx_valid), 16'd0);

`ifdef UART_PARITY_EN
    // Parity: bad parity still pushes the word and sets perr
    checkOutput("perr before", 16'(perr), 16'd0);
    driveFrame(12'h682, NBITS);
    checkOutput("perr set", 16'(perr), 16'd1);
    popOne("parity word", 8'h41);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("perr cleared", 16'(perr), 16'd0);
`else
    checkOutput("perr tied low", 16'(perr), 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
